// File: rtl/data_output.sv
// CPU output port: a small FIFO of CPU-written words, drained to an external
// device one word per strobe/acknowledge handshake.
module data_output #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             port_id,
    input  logic             port_write,
    input  logic             port_read,
    input  logic [WIDTH-1:0] data_in,
    output logic [3:0]       data_out,
    output logic [WIDTH-1:0] device_bus,
    output logic             device_strobe,
    input  logic             device_ack
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STROBE  = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [1:0]            state;
    logic                  overflow;
    logic                  full;
    logic                  empty;
    logic                  busy;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  clear;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // Full/empty come from the pre-edge count, so a pop never makes room for a same-cycle push.
    assign push  = port_write && port_id && !full;
    assign drop  = port_write && port_id && full;
    assign clear = port_read && !port_id;
    assign pop   = (state == IDLE) && !empty;

    assign data_out = {overflow, busy, empty, full};

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + COUNT_ONE;
            end else if (pop && !push) begin
                count <= count - COUNT_ONE;
            end
            // A dropped word takes priority over a status-read clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            device_bus    <= '0;
            device_strobe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        device_bus    <= mem[rd_ptr];
                        device_strobe <= 1'b1;
                        state         <= STROBE;
                    end
                end
                STROBE: begin
                    if (device_ack) begin
                        device_strobe <= 1'b0;
                        state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!device_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    device_strobe <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_output.sv
// Directed self-checking bench for data_output: reset, single handshake,
// fill/overflow, overflow clear, streaming wrap-around, reset mid-handshake.
module tb_data_output;

    logic       clock;
    logic       reset;
    logic       port_id;
    logic       port_write;
    logic       port_read;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic [3:0] device_bus;
    logic       device_strobe;
    logic       device_ack;

    int checks = 0;
    int errors = 0;

    data_output #(.WIDTH(4), .DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .port_id       (port_id),
        .port_write    (port_write),
        .port_read     (port_read),
        .data_in       (data_in),
        .data_out      (data_out),
        .device_bus    (device_bus),
        .device_strobe (device_strobe),
        .device_ack    (device_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [3:0] d);
        port_id    = 1'b1;
        port_write = 1'b1;
        data_in    = d;
        tick();
        port_write = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [3:0] exp);
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("[TB] FAIL %s: data_out=%b expected=%b", name, data_out, exp);
        end
    endtask

    task automatic handshake(input string name, input logic [3:0] exp);
        int n = 0;
        while (device_strobe !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (device_strobe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_strobe_timeout: strobe=%b expected=1", name, device_strobe);
        end
        checks++;
        if (device_bus !== exp) begin
            errors++;
            $display("[TB] FAIL %s_bus: device_bus=%h expected=%h", name, device_bus, exp);
        end
        device_ack = 1'b1;
        tick();
        checks++;
        if (device_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_strobe_fall: strobe=%b expected=0", name, device_strobe);
        end
        device_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_status("reset_status", 4'b0010);
        checks++;
        if (device_strobe !== 1'b0 || device_bus !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_device: strobe=%b bus=%h expected strobe=0 bus=0",
                     device_strobe, device_bus);
        end
    endtask

    task automatic test_port0_write();
        port_id    = 1'b0;
        port_write = 1'b1;
        data_in    = 4'h9;
        tick();
        port_write = 1'b0;
        tick();
        check_status("port0_write_ignored", 4'b0010);
        checks++;
        if (device_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL port0_write_strobe: strobe=%b expected=0", device_strobe);
        end
    endtask

    task automatic test_single();
        do_write(4'hA);
        check_status("single_after_push", 4'b0000);
        checks++;
        if (device_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_strobe_early: strobe=%b expected=0", device_strobe);
        end
        tick();
        checks++;
        if (device_strobe !== 1'b1 || device_bus !== 4'hA) begin
            errors++;
            $display("[TB] FAIL single_present: strobe=%b bus=%h expected strobe=1 bus=a",
                     device_strobe, device_bus);
        end
        check_status("single_busy", 4'b0110);
        tick();
        device_ack = 1'b1;
        tick();
        checks++;
        if (device_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_strobe_fall: strobe=%b expected=0", device_strobe);
        end
        check_status("single_release_busy", 4'b0110);
        tick();
        check_status("single_ack_held", 4'b0110);
        device_ack = 1'b0;
        tick();
        check_status("single_done", 4'b0010);
        checks++;
        if (device_bus !== 4'hA) begin
            errors++;
            $display("[TB] FAIL single_bus_kept: device_bus=%h expected=a", device_bus);
        end
    endtask

    task automatic test_overflow();
        device_ack = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            do_write(4'(i));
        end
        check_status("fill_full", 4'b0101);
        do_write(4'h6);
        check_status("overflow_set", 4'b1101);
        port_id   = 1'b0;
        port_read = 1'b1;
        tick();
        port_read = 1'b0;
        check_status("overflow_clear", 4'b0101);
        port_id    = 1'b1;
        port_read  = 1'b1;
        port_write = 1'b1;
        data_in    = 4'h7;
        tick();
        port_read  = 1'b0;
        port_write = 1'b0;
        check_status("overflow_with_read", 4'b1101);
        port_id   = 1'b1;
        port_read = 1'b1;
        tick();
        port_read = 1'b0;
        check_status("port1_read_ignored", 4'b1101);
        for (int i = 1; i <= 5; i++) begin
            handshake($sformatf("drain%0d", i), 4'(i));
        end
        tick();
        check_status("drain_done", 4'b1010);
        port_id   = 1'b0;
        port_read = 1'b1;
        tick();
        port_read = 1'b0;
        check_status("final_clear", 4'b0010);
    endtask

    task automatic test_stream();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int n = 0;
                    while (data_out[0] === 1'b1 && n < 50) begin
                        tick();
                        n++;
                    end
                    do_write(4'(i));
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    handshake($sformatf("stream%0d", k), 4'(k));
                end
            end
        join
        tick();
        check_status("stream_done", 4'b0010);
    endtask

    task automatic test_reset_mid();
        device_ack = 1'b0;
        do_write(4'h1);
        do_write(4'h2);
        do_write(4'h3);
        check_status("mid_queued", 4'b0100);
        checks++;
        if (device_strobe !== 1'b1 || device_bus !== 4'h1) begin
            errors++;
            $display("[TB] FAIL mid_present: strobe=%b bus=%h expected strobe=1 bus=1",
                     device_strobe, device_bus);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (device_strobe !== 1'b0 || device_bus !== 4'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_device: strobe=%b bus=%h expected strobe=0 bus=0",
                     device_strobe, device_bus);
        end
        check_status("mid_reset_status", 4'b0010);
        device_ack = 1'b1;
        tick();
        tick();
        device_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (device_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_late_ack_strobe: strobe=%b expected=0", device_strobe);
        end
        check_status("mid_late_ack_status", 4'b0010);
    endtask

    initial begin
        reset      = 1'b1;
        port_id    = 1'b0;
        port_write = 1'b0;
        port_read  = 1'b0;
        data_in    = 4'h0;
        device_ack = 1'b0;
        test_reset();
        test_port0_write();
        test_single();
        test_overflow();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
